// File: rtl/multicycle_control_unit_if.sv
// Control bus between the multicycle control unit and its datapath.
//   master : control unit side (receives opcode/mem_ready, drives controls)
//   slave  : datapath side (drives opcode/mem_ready, receives controls)
// Signals:
//   opcode       IR[31:26], stable from DECODE until the instruction ends
//   mem_ready    memory completes the current read/write this cycle
//   PCWrite .. PCSource   multicycle datapath control lines
//   state        current FSM state code (debug)
//   illegal_op   sticky undefined-opcode flag
//   instr_count  retired-instruction counter (wraps)
interface multicycle_control_unit_if #(
    parameter int OPCODE_W = 6,
    parameter int CNT_W    = 16
);
    logic [OPCODE_W-1:0] opcode;
    logic                mem_ready;
    logic                PCWrite;
    logic                PCWriteCond;
    logic                IorD;
    logic                MemRead;
    logic                MemWrite;
    logic                IRWrite;
    logic                MemToReg;
    logic                RegDst;
    logic                RegWrite;
    logic                ALUSrcA;
    logic [1:0]          ALUSrcB;
    logic [1:0]          ALUOp;
    logic [1:0]          PCSource;
    logic [3:0]          state;
    logic                illegal_op;
    logic [CNT_W-1:0]    instr_count;

    modport master (
        input  opcode, mem_ready,
        output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
               MemToReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp,
               PCSource, state, illegal_op, instr_count
    );

    modport slave (
        output opcode, mem_ready,
        input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
               MemToReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp,
               PCSource, state, illegal_op, instr_count
    );
endinterface

// File: rtl/multicycle_control_unit.sv
// Multicycle MIPS-subset control unit: Moore FSM sequencing fetch, decode,
// execute, memory and writeback for R-type, lw, sw, beq, addi, andi, ori,
// xori, slti and j, with a memory ready handshake, a sticky illegal-opcode
// flag and a wrapping retired-instruction counter.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    control bus (master modport): opcode/mem_ready in, control
//          lines, state code, illegal_op and instr_count out
module multicycle_control_unit #(
    parameter int OPCODE_W    = 6,
    parameter int MEM_WAIT_EN = 1,
    parameter int CNT_W       = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    multicycle_control_unit_if.master bus
);

    localparam logic [OPCODE_W-1:0] OP_RTYPE = OPCODE_W'(6'b000000);
    localparam logic [OPCODE_W-1:0] OP_J     = OPCODE_W'(6'b000010);
    localparam logic [OPCODE_W-1:0] OP_BEQ   = OPCODE_W'(6'b000100);
    localparam logic [OPCODE_W-1:0] OP_ADDI  = OPCODE_W'(6'b001000);
    localparam logic [OPCODE_W-1:0] OP_SLTI  = OPCODE_W'(6'b001010);
    localparam logic [OPCODE_W-1:0] OP_ANDI  = OPCODE_W'(6'b001100);
    localparam logic [OPCODE_W-1:0] OP_ORI   = OPCODE_W'(6'b001101);
    localparam logic [OPCODE_W-1:0] OP_XORI  = OPCODE_W'(6'b001110);
    localparam logic [OPCODE_W-1:0] OP_LW    = OPCODE_W'(6'b100011);
    localparam logic [OPCODE_W-1:0] OP_SW    = OPCODE_W'(6'b101011);

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXEC   = 4'd6,
        ALUWB  = 4'd7,
        BRANCH = 4'd8,
        IEXEC  = 4'd9,
        IWB    = 4'd10,
        JUMP   = 4'd11
    } state_t;

    state_t           state_q, state_d;
    logic             illegal_q;
    logic [CNT_W-1:0] cnt_q;

    logic       ready;
    logic       illegal_set;
    logic       retire;
    logic       pcwrite, pcwritecond, iord, memread, memwrite, irwrite;
    logic       memtoreg, regdst, regwrite, alusrca;
    logic [1:0] alusrcb, aluop, pcsource;

    // With wait states disabled every memory access completes in one cycle.
    assign ready = (MEM_WAIT_EN != 0) ? bus.mem_ready : 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= FETCH;
            illegal_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q <= state_d;
            if (illegal_set) begin
                illegal_q <= 1'b1;
            end
            if (retire) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        state_d     = FETCH;
        illegal_set = 1'b0;
        retire      = 1'b0;
        pcwrite     = 1'b0;
        pcwritecond = 1'b0;
        iord        = 1'b0;
        memread     = 1'b0;
        memwrite    = 1'b0;
        irwrite     = 1'b0;
        memtoreg    = 1'b0;
        regdst      = 1'b0;
        regwrite    = 1'b0;
        alusrca     = 1'b0;
        alusrcb     = 2'b00;
        aluop       = 2'b00;
        pcsource    = 2'b00;

        case (state_q)
            FETCH: begin
                memread = 1'b1;
                alusrcb = 2'b01;
                irwrite = ready;
                pcwrite = ready;
                state_d = ready ? DECODE : FETCH;
            end
            DECODE: begin
                alusrcb = 2'b11;
                case (bus.opcode)
                    OP_LW, OP_SW:                              state_d = MEMADR;
                    OP_RTYPE:                                  state_d = EXEC;
                    OP_BEQ:                                    state_d = BRANCH;
                    OP_ADDI, OP_ANDI, OP_ORI, OP_XORI, OP_SLTI: state_d = IEXEC;
                    OP_J:                                      state_d = JUMP;
                    default: begin
                        state_d     = FETCH;
                        illegal_set = 1'b1;
                    end
                endcase
            end
            MEMADR: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                state_d = (bus.opcode == OP_SW) ? MEMWR : MEMRD;
            end
            MEMRD: begin
                memread = 1'b1;
                iord    = 1'b1;
                state_d = ready ? MEMWB : MEMRD;
            end
            MEMWB: begin
                memtoreg = 1'b1;
                regwrite = 1'b1;
                retire   = 1'b1;
                state_d  = FETCH;
            end
            MEMWR: begin
                memwrite = 1'b1;
                iord     = 1'b1;
                retire   = ready;
                state_d  = ready ? FETCH : MEMWR;
            end
            EXEC: begin
                alusrca = 1'b1;
                aluop   = 2'b10;
                state_d = ALUWB;
            end
            ALUWB: begin
                regdst   = 1'b1;
                regwrite = 1'b1;
                retire   = 1'b1;
                state_d  = FETCH;
            end
            BRANCH: begin
                alusrca     = 1'b1;
                aluop       = 2'b01;
                pcwritecond = 1'b1;
                pcsource    = 2'b01;
                retire      = 1'b1;
                state_d     = FETCH;
            end
            IEXEC: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                case (bus.opcode)
                    OP_ANDI, OP_ORI, OP_XORI: aluop = 2'b11;
                    OP_SLTI:                  aluop = 2'b10;
                    default:                  aluop = 2'b00;
                endcase
                state_d = IWB;
            end
            IWB: begin
                regwrite = 1'b1;
                retire   = 1'b1;
                state_d  = FETCH;
            end
            JUMP: begin
                pcwrite  = 1'b1;
                pcsource = 2'b10;
                retire   = 1'b1;
                state_d  = FETCH;
            end
            default: begin
                state_d = FETCH;
            end
        endcase
    end

    // Controls are gated by rst_n so an asserted reset kills any in-flight
    // write immediately rather than waiting for the state register to clear.
    assign bus.PCWrite     = rst_n & pcwrite;
    assign bus.PCWriteCond = rst_n & pcwritecond;
    assign bus.IorD        = rst_n & iord;
    assign bus.MemRead     = rst_n & memread;
    assign bus.MemWrite    = rst_n & memwrite;
    assign bus.IRWrite     = rst_n & irwrite;
    assign bus.MemToReg    = rst_n & memtoreg;
    assign bus.RegDst      = rst_n & regdst;
    assign bus.RegWrite    = rst_n & regwrite;
    assign bus.ALUSrcA     = rst_n & alusrca;
    assign bus.ALUSrcB     = rst_n ? alusrcb  : 2'b00;
    assign bus.ALUOp       = rst_n ? aluop    : 2'b00;
    assign bus.PCSource    = rst_n ? pcsource : 2'b00;
    assign bus.state       = state_q;
    assign bus.illegal_op  = illegal_q;
    assign bus.instr_count = cnt_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Self-checking bench for multicycle_control_unit: table-driven instruction
// vectors, hand-written multi-cycle corner sequences, and randomized
// opcode/mem_ready traffic checked against an instruction-level model.
module tb_multicycle_control_unit;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_SLTI = 6'b001010;
    localparam logic [5:0] OP_ANDI = 6'b001100;
    localparam logic [5:0] OP_ORI  = 6'b001101;
    localparam logic [5:0] OP_XORI = 6'b001110;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BAD  = 6'b111111;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    multicycle_control_unit_if #(.OPCODE_W(6), .CNT_W(16)) bw ();
    multicycle_control_unit_if #(.OPCODE_W(6), .CNT_W(16)) bn ();

    multicycle_control_unit #(.OPCODE_W(6), .MEM_WAIT_EN(1), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bw)
    );
    multicycle_control_unit #(.OPCODE_W(6), .MEM_WAIT_EN(0), .CNT_W(16)) dut_nw (
        .clk(clk), .rst_n(rst_n), .bus(bn)
    );

    // {PCWrite,PCWriteCond,IorD,MemRead,MemWrite,IRWrite,MemToReg,RegDst,
    //  RegWrite,ALUSrcA,ALUSrcB[1:0],ALUOp[1:0],PCSource[1:0]}
    logic [15:0] ctl_w;
    assign ctl_w = {bw.PCWrite, bw.PCWriteCond, bw.IorD, bw.MemRead, bw.MemWrite,
                    bw.IRWrite, bw.MemToReg, bw.RegDst, bw.RegWrite, bw.ALUSrcA,
                    bw.ALUSrcB, bw.ALUOp, bw.PCSource};

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    endtask

    // Required control word for a given state code, straight from the
    // per-state output list.
    function automatic logic [15:0] exp_ctl(input logic [3:0] st, input logic [5:0] op,
                                            input logic rdy);
        logic pw, pwc, iord, mr, mw, irw, m2r, rd, rw, sa;
        logic [1:0] sb, ao, ps;
        {pw, pwc, iord, mr, mw, irw, m2r, rd, rw, sa} = '0;
        sb = 2'b00; ao = 2'b00; ps = 2'b00;
        case (st)
            4'd0:  begin mr = 1'b1; sb = 2'b01; irw = rdy; pw = rdy; end
            4'd1:  sb = 2'b11;
            4'd2:  begin sa = 1'b1; sb = 2'b10; end
            4'd3:  begin mr = 1'b1; iord = 1'b1; end
            4'd4:  begin m2r = 1'b1; rw = 1'b1; end
            4'd5:  begin mw = 1'b1; iord = 1'b1; end
            4'd6:  begin sa = 1'b1; ao = 2'b10; end
            4'd7:  begin rd = 1'b1; rw = 1'b1; end
            4'd8:  begin sa = 1'b1; ao = 2'b01; pwc = 1'b1; ps = 2'b01; end
            4'd9:  begin
                       sa = 1'b1; sb = 2'b10;
                       if (op == OP_ADDI)      ao = 2'b00;
                       else if (op == OP_SLTI) ao = 2'b10;
                       else                    ao = 2'b11;
                   end
            4'd10: rw = 1'b1;
            4'd11: begin pw = 1'b1; ps = 2'b10; end
            default: ;
        endcase
        return {pw, pwc, iord, mr, mw, irw, m2r, rd, rw, sa, sb, ao, ps};
    endfunction

    // Drive one cycle's inputs, then check state and the full control word.
    task automatic step_w(input logic [5:0] op, input logic rdy, input logic [3:0] st,
                          input string nm);
        bw.opcode    = op;
        bw.mem_ready = rdy;
        #1;
        chk({nm, " state"}, 32'(bw.state), 32'(st));
        chk({nm, " ctl"}, 32'(ctl_w), 32'(exp_ctl(st, op, rdy)));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Instruction-level model: each opcode expands to its list of phases.
    logic [3:0]  mq[$];
    logic [15:0] m_cnt;
    logic        m_ill;
    logic [5:0]  m_op;

    task automatic load_instr(input logic [5:0] op);
        mq.push_back(4'd0);
        mq.push_back(4'd1);
        case (op)
            OP_LW:   begin mq.push_back(4'd2); mq.push_back(4'd3); mq.push_back(4'd4); end
            OP_SW:   begin mq.push_back(4'd2); mq.push_back(4'd5); end
            OP_R:    begin mq.push_back(4'd6); mq.push_back(4'd7); end
            OP_BEQ:  mq.push_back(4'd8);
            OP_ADDI, OP_ANDI, OP_ORI, OP_XORI, OP_SLTI:
                     begin mq.push_back(4'd9); mq.push_back(4'd10); end
            OP_J:    mq.push_back(4'd11);
            default: ;
        endcase
    endtask

    typedef struct {
        logic [5:0]  op;
        int          ncyc;
        logic [23:0] path;     // nibble i = state code in cycle i
        logic [1:0]  alu2;     // ALUOp in cycle 2
        logic [5:0]  rwmask;   // bit i = RegWrite in cycle i
        logic [1:0]  ps_last;  // PCSource in the last cycle
    } vec_t;

    vec_t vt[10];
    logic [5:0] legal[10] = '{OP_R, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_ANDI,
                              OP_ORI, OP_XORI, OP_SLTI, OP_J};

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected $finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [15:0] c0;
        logic [3:0]  cur;

        vt[0] = '{OP_R,    4, 24'h007610, 2'b10, 6'b001000, 2'b00};
        vt[1] = '{OP_BEQ,  3, 24'h000810, 2'b01, 6'b000000, 2'b01};
        vt[2] = '{OP_J,    3, 24'h000B10, 2'b00, 6'b000000, 2'b10};
        vt[3] = '{OP_SLTI, 4, 24'h00A910, 2'b10, 6'b001000, 2'b00};
        vt[4] = '{OP_ORI,  4, 24'h00A910, 2'b11, 6'b001000, 2'b00};
        vt[5] = '{OP_LW,   5, 24'h043210, 2'b00, 6'b010000, 2'b00};
        vt[6] = '{OP_SW,   4, 24'h005210, 2'b00, 6'b000000, 2'b00};
        vt[7] = '{OP_ADDI, 4, 24'h00A910, 2'b00, 6'b001000, 2'b00};
        vt[8] = '{OP_ANDI, 4, 24'h00A910, 2'b11, 6'b001000, 2'b00};
        vt[9] = '{OP_XORI, 4, 24'h00A910, 2'b11, 6'b001000, 2'b00};

        bw.opcode = OP_R;  bw.mem_ready = 1'b0;
        bn.opcode = OP_LW; bn.mem_ready = 1'b0;
        rst_n = 1'b0;
        #2;
        chk("reset state", 32'(bw.state), 32'd0);
        chk("reset ctl", 32'(ctl_w), 32'd0);
        chk("reset illegal", 32'(bw.illegal_op), 32'd0);
        chk("reset count", 32'(bw.instr_count), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Table-driven instructions with mem_ready held high.
        for (int r = 0; r < 10; r++) begin
            c0 = bw.instr_count;
            for (int i = 0; i < vt[r].ncyc; i++) begin
                bw.opcode = vt[r].op;
                bw.mem_ready = 1'b1;
                #1;
                chk($sformatf("tbl%0d c%0d state", r, i), 32'(bw.state),
                    32'(vt[r].path[4*i +: 4]));
                chk($sformatf("tbl%0d c%0d RegWrite", r, i), 32'(bw.RegWrite),
                    32'(vt[r].rwmask[i]));
                if (i == 2)
                    chk($sformatf("tbl%0d ALUOp", r), 32'(bw.ALUOp), 32'(vt[r].alu2));
                if (i == vt[r].ncyc - 1)
                    chk($sformatf("tbl%0d PCSource", r), 32'(bw.PCSource),
                        32'(vt[r].ps_last));
                @(negedge clk);
            end
            #1;
            chk($sformatf("tbl%0d back to FETCH", r), 32'(bw.state), 32'd0);
            chk($sformatf("tbl%0d count", r), 32'(bw.instr_count), 32'(16'(c0 + 16'd1)));
            if (r == 4) chk("count after 5", 32'(bw.instr_count), 32'd5);
        end

        // Reset asserted mid-MEMRD.
        step_w(OP_LW, 1'b1, 4'd0, "rst f");  @(negedge clk);
        step_w(OP_LW, 1'b1, 4'd1, "rst d");  @(negedge clk);
        step_w(OP_LW, 1'b1, 4'd2, "rst a");  @(negedge clk);
        step_w(OP_LW, 1'b0, 4'd3, "rst rd");
        rst_n = 1'b0;
        #1;
        chk("midrst state", 32'(bw.state), 32'd0);
        chk("midrst ctl", 32'(ctl_w), 32'd0);
        chk("midrst count", 32'(bw.instr_count), 32'd0);
        @(posedge clk);
        #1;
        chk("midrst hold ctl", 32'(ctl_w), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step_w(OP_LW, 1'b0, 4'd0, "release");
        chk("release MemRead", 32'(bw.MemRead), 32'd1);
        chk("release IorD", 32'(bw.IorD), 32'd0);
        @(negedge clk);
        step_w(OP_LW, 1'b1, 4'd0, "lw f"); @(negedge clk);
        step_w(OP_LW, 1'b1, 4'd1, "lw d"); @(negedge clk);
        step_w(OP_LW, 1'b1, 4'd2, "lw a"); @(negedge clk);
        step_w(OP_LW, 1'b1, 4'd3, "lw r"); @(negedge clk);
        step_w(OP_LW, 1'b1, 4'd4, "lw wb"); @(negedge clk);
        #1;
        chk("lw count", 32'(bw.instr_count), 32'd1);

        // sw with three wait cycles in MEMWR.
        step_w(OP_SW, 1'b1, 4'd0, "sw f"); @(negedge clk);
        step_w(OP_SW, 1'b1, 4'd1, "sw d"); @(negedge clk);
        step_w(OP_SW, 1'b1, 4'd2, "sw a"); @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            step_w(OP_SW, (k == 3), 4'd5, $sformatf("sw wr%0d", k));
            chk($sformatf("sw MemWrite%0d", k), 32'(bw.MemWrite), 32'd1);
            @(negedge clk);
        end
        #1;
        chk("sw done state", 32'(bw.state), 32'd0);
        chk("sw count", 32'(bw.instr_count), 32'd2);

        // Illegal opcode followed by addi.
        step_w(OP_BAD, 1'b1, 4'd0, "ill f"); @(negedge clk);
        step_w(OP_BAD, 1'b1, 4'd1, "ill d");
        chk("ill before", 32'(bw.illegal_op), 32'd0);
        @(negedge clk);
        step_w(OP_ADDI, 1'b1, 4'd0, "addi f");
        chk("ill set", 32'(bw.illegal_op), 32'd1);
        chk("ill not counted", 32'(bw.instr_count), 32'd2);
        @(negedge clk);
        step_w(OP_ADDI, 1'b1, 4'd1, "addi d"); @(negedge clk);
        step_w(OP_ADDI, 1'b1, 4'd9, "addi x"); @(negedge clk);
        step_w(OP_ADDI, 1'b1, 4'd10, "addi wb"); @(negedge clk);
        #1;
        chk("ill sticky", 32'(bw.illegal_op), 32'd1);
        chk("addi count", 32'(bw.instr_count), 32'd3);

        // Wait states disabled: lw with mem_ready low runs in 5 cycles.
        bw.mem_ready = 1'b0;
        bn.opcode = OP_LW;
        bn.mem_ready = 1'b0;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            #1;
            chk($sformatf("nw c%0d state", i), 32'(bn.state), 32'((i == 5) ? 0 : i));
            if (i == 0) chk("nw IRWrite", 32'(bn.IRWrite), 32'd1);
            if (i == 3) chk("nw MemRead", 32'(bn.MemRead), 32'd1);
            if (i == 5) chk("nw count", 32'(bn.instr_count), 32'd1);
            @(negedge clk);
        end

        // Random opcodes and mem_ready against the instruction-level model.
        do_reset();
        mq.delete();
        m_cnt = '0;
        m_ill = 1'b0;
        m_op  = OP_R;
        for (int c = 0; c < 3000; c++) begin
            if (mq.size() == 0) begin
                if ($urandom_range(0, 4) == 0) m_op = 6'($urandom);
                else m_op = legal[$urandom_range(0, 9)];
                bw.opcode = m_op;
                load_instr(m_op);
            end
            bw.mem_ready = ($urandom_range(0, 3) != 0);
            #1;
            cur = mq[0];
            chk($sformatf("rnd%0d state", c), 32'(bw.state), 32'(cur));
            chk($sformatf("rnd%0d ctl", c), 32'(ctl_w), 32'(exp_ctl(cur, m_op, bw.mem_ready)));
            chk($sformatf("rnd%0d illegal", c), 32'(bw.illegal_op), 32'(m_ill));
            chk($sformatf("rnd%0d count", c), 32'(bw.instr_count), 32'(m_cnt));
            if (!((cur == 4'd0 || cur == 4'd3 || cur == 4'd5) && !bw.mem_ready)) begin
                void'(mq.pop_front());
                if (mq.size() == 0) begin
                    if (cur == 4'd1) m_ill = 1'b1;
                    else m_cnt = m_cnt + 16'd1;
                end
            end
            @(negedge clk);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
- Multicycle successor to the single-cycle main decoder: a Moore FSM that sequences fetch, decode, execute, memory and writeback over several clocks for the same MIPS subset (R-type, lw, sw, beq, addi, andi/ori/xori, slti, j).
- Drives the shared-memory multicycle datapath (IR, PC, A/B and ALUOut registers).
- Adds a memory ready handshake with optional wait states, a sticky illegal-opcode flag and a retired-instruction counter.

Parameters:
- OPCODE_W, 6, opcode field width.
- MEM_WAIT_EN, 1, 1 = memory states wait for mem_ready; 0 = mem_ready ignored (treated as 1).
- CNT_W, 16, width of retired-instruction counter.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- opcode  in  OPCODE_W  IR[31:26]; stable from DECODE until instruction completes.
- mem_ready  in  1  memory completes the current read/write this cycle.
- PCWrite  out  1  unconditional PC load.
- PCWriteCond  out  1  PC load if ALU zero (beq).
- IorD  out  1  0 = PC addresses memory, 1 = ALUOut.
- MemRead  out  1  memory read request.
- MemWrite  out  1  memory write request.
- IRWrite  out  1  instruction register load.
- MemToReg  out  1  writeback source, 1 = MDR.
- RegDst  out  1  1 = rd, 0 = rt.
- RegWrite  out  1  register file write.
- ALUSrcA  out  1  0 = PC, 1 = A.
- ALUSrcB  out  2  00 B, 01 const 4, 10 sign-ext imm, 11 imm<<2.
- ALUOp  out  2  00 add, 01 sub, 10 funct/slt, 11 logic-imm.
- PCSource  out  2  00 ALU result, 01 ALUOut, 10 jump target.
- state  out  4  current state code (debug).
- illegal_op  out  1  sticky undefined-opcode flag.
- instr_count  out  CNT_W  retired instructions, wraps.

Behaviour:
- State codes: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, IEXEC=9, IWB=10, JUMP=11. Codes 12-15 are unreachable and return to FETCH next cycle with all outputs 0.
- Reset: while rst_n=0, state=FETCH, illegal_op=0, instr_count=0. All control outputs are forced 0 while reset is asserted. Outputs for FETCH appear the first cycle after release.
- Reset mid-instruction aborts it immediately (asynchronous). No partial write is issued after reset asserts.
- Moore outputs decode from state. Only PCWrite/IRWrite in FETCH are qualified by mem_ready. Any output not listed for a state is 0.
- FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00. IRWrite=PCWrite=mem_ready. Stays in FETCH until mem_ready=1, then goes to DECODE.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00. Next state by opcode:
  - lw/sw -> MEMADR
  - R-type -> EXEC
  - beq -> BRANCH
  - addi/andi/ori/xori/slti -> IEXEC
  - j -> JUMP
  - any other opcode -> FETCH, sets illegal_op (sticky until reset), not counted.
- MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Next state: lw -> MEMRD, sw -> MEMWR.
- MEMRD: MemRead=1, IorD=1. Holds until mem_ready, then goes to MEMWB.
- MEMWB: MemToReg=1, RegDst=0, RegWrite=1. Next state FETCH.
- MEMWR: MemWrite=1, IorD=1. Holds until mem_ready, then goes to FETCH.
- EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=10. Next state ALUWB.
- ALUWB: RegDst=1, MemToReg=0, RegWrite=1. Next state FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01. Next state FETCH.
- IEXEC: ALUSrcA=1, ALUSrcB=10. ALUOp: addi 00, andi/ori/xori 11, slti 10. Next state IWB.
- IWB: RegDst=0, MemToReg=0, RegWrite=1. Next state FETCH.
- JUMP: PCWrite=1, PCSource=10. Next state FETCH.
- Cycle counts with zero wait states:
  - lw 5, sw 4, R-type 4, addi-class 4, beq 3, j 3.
  - Each cycle mem_ready is low in a memory state adds one cycle.
- With MEM_WAIT_EN=0, memory states last exactly one cycle.
- instr_count increments by 1 on each transition into FETCH from MEMWB, MEMWR, ALUWB, BRANCH, IWB or JUMP. It wraps at 2^CNT_W.

Test Plan:
- Reset: assert rst_n=0 mid-MEMRD (state=3) -> state=0 immediately and all outputs 0. Release rst_n -> next cycle MemRead=1, IorD=0.
- lw (opcode 100011) with mem_ready=1: states 0,1,2,3,4,0 -> RegWrite=1 and MemToReg=1 only in state 4; instr_count 0->1.
- sw with mem_ready held low for 3 cycles in MEMWR -> MemWrite=1 for 4 cycles, then FETCH; no RegWrite anywhere.
- Sequence R-type, beq, j, slti (001010), ori (001101) -> cycle counts 4,3,3,4,4. ALUOp=10 in IEXEC for slti and 11 for ori; PCWriteCond=1 only in BRANCH; PCSource=10 in JUMP; instr_count=5.
- Opcode 111111 -> DECODE then FETCH, illegal_op=1 and stays 1 through a following valid addi; instr_count unchanged by the illegal opcode.
- MEM_WAIT_EN=0 with mem_ready=0: lw completes in 5 cycles; IRWrite=1 in the single FETCH cycle.
